siso_tx_ctrl: RTL
=================

SISO_TX_CTRL -- requirements
Module: siso_tx_ctrl

Interface
REQ-001: Parameter WIDTH, default 8, is the frame length in bits; legal range 2..32.
REQ-002: Parameter GAP_CYCLES, default 1, is the number of idle cycles after each frame; legal range 0..15.
REQ-003: clk  input  1  single clock for the block; all state updates on its rising edge.
REQ-004: reset_n  input  1  asynchronous, active-low reset.
REQ-005: din_valid  input  1  a parallel word is offered on din.
REQ-006: din  input  WIDTH  parallel word to serialize.
REQ-007: msb_first  input  1  bit order for the offered word: 1 = MSB first, 0 = LSB first.
REQ-008: abort  input  1  synchronous request to terminate the current frame.
REQ-009: din_ready  output  1  block can accept a word this cycle.
REQ-010: sdo  output  1  serial data out.
REQ-011: sdo_valid  output  1  sdo carries a frame bit this cycle.
REQ-012: done  output  1  one-cycle pulse marking the last bit of a completed frame.
REQ-013: busy  output  1  block is in SHIFT or GAP.

Function
REQ-014: The FSM states SHALL be IDLE, SHIFT and GAP, and all outputs SHALL be driven from registers.
REQ-015: IDLE: din_ready=1, busy=0, sdo=0, sdo_valid=0, done=0.
REQ-016: A word is accepted at a rising edge where din_valid=1 and din_ready=1, and din and msb_first are captured at that edge.
REQ-017: After an accept, the next state SHALL be SHIFT, with the first bit on sdo and sdo_valid=1 in the cycle immediately after the accept edge (latency 1 cycle).
REQ-018: SHIFT presents exactly WIDTH bits on consecutive cycles, one per cycle, in the captured bit order, with din_ready=0 and busy=1.
REQ-019: A bit counter of width clog2(WIDTH+1) tracks the bits sent, and done=1 only in the cycle the WIDTH-th bit is on sdo.
REQ-020: After the last bit, the FSM SHALL enter GAP for GAP_CYCLES cycles (sdo=0, sdo_valid=0, busy=1, din_ready=0) and then enter IDLE.
REQ-021: With GAP_CYCLES=0, the FSM SHALL go directly from the last SHIFT cycle to IDLE, so din_ready=1 in the next cycle.
REQ-022: Words are never accepted outside IDLE, and din_valid held high while busy SHALL have no effect.
REQ-023: The accept path SHALL have no combinational dependence of din_ready on din_valid.
REQ-024: abort=1 sampled during SHIFT SHALL force IDLE at that edge: no done pulse, no GAP, sdo=0, sdo_valid=0 in the next cycle.
REQ-025: abort during IDLE or GAP SHALL be ignored, and abort in the same cycle as an accept SHALL be ignored (the accept wins).
REQ-026: Changes on din or msb_first after the accept edge SHALL not affect the frame in progress.

Reset
REQ-027: reset_n=0 SHALL immediately, without waiting for clk, force IDLE, clear the bit counter and shift register, and drive sdo=0, sdo_valid=0, done=0, busy=0, din_ready=0.
REQ-028: din_ready SHALL rise to 1 at the first rising clk edge after reset_n deasserts, and no word SHALL be accepted at that edge.
REQ-029: Reset asserted mid-frame SHALL discard the frame with no done pulse.

Verification (WIDTH=8, GAP_CYCLES=2, accept edge = E0)
REQ-030: din=8'hA5, msb_first=1 -> sdo=1,0,1,0,0,1,0,1 on cycles 1..8 with sdo_valid=1; done=1 only in cycle 8; din_ready=1 again in cycle 11.
REQ-031: din=8'h01, msb_first=0 -> sdo=1,0,0,0,0,0,0,0; then din=8'h01, msb_first=1 -> sdo=0,0,0,0,0,0,0,1.
REQ-032: din_valid held high continuously with din changed to 8'hFF during the frame -> first frame unaffected; the second accept occurs only when din_ready=1 (cycle 11); the second frame is all ones.
REQ-033: abort=1 during cycle 3 of a frame -> sdo_valid=0, busy=0, din_ready=1 from cycle 4; done never asserts.
REQ-034: reset_n pulsed low mid-cycle during bit 5 -> all outputs 0 before the next clk edge; after release, din_ready=1 at the first edge; the next accepted frame is correct.
REQ-035: GAP_CYCLES=0 build, two back-to-back words 8'hC3, 8'h3C -> frames separated by exactly one IDLE cycle; done pulses in cycles 8 and 17.

Source files
------------

// File: rtl/siso_tx_ctrl.sv
// Parallel-to-serial frame transmitter with selectable bit order,
// abort and a programmable inter-frame idle gap.
module siso_tx_ctrl #(
  parameter int WIDTH      = 8,
  parameter int GAP_CYCLES = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             din_valid,
  input  logic [WIDTH-1:0] din,
  input  logic             msb_first,
  input  logic             abort,
  output logic             din_ready,
  output logic             sdo,
  output logic             sdo_valid,
  output logic             done,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH);
  localparam logic [3:0] GAP_LD =
    4'(GAP_CYCLES > 0 ? GAP_CYCLES - 1 : 0);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    GAP
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] sh;
  logic [CW-1:0]    cnt;
  logic [3:0]       gcnt;
  logic             msb_q;
  logic             accept;

  // din_ready is a register, so accept never loops back into it
  assign accept = (state == IDLE) && din_ready && din_valid;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      sh        <= '0;
      cnt       <= '0;
      gcnt      <= '0;
      msb_q     <= 1'b0;
      din_ready <= 1'b0;
      sdo       <= 1'b0;
      sdo_valid <= 1'b0;
      done      <= 1'b0;
      busy      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          din_ready <= 1'b1;
          if (accept) begin
            state     <= SHIFT;
            msb_q     <= msb_first;
            sdo       <= msb_first ? din[WIDTH-1] : din[0];
            sh        <= msb_first ? din << 1 : din >> 1;
            cnt       <= CW'(1);
            sdo_valid <= 1'b1;
            done      <= 1'b0;
            busy      <= 1'b1;
            din_ready <= 1'b0;
          end
        end
        SHIFT: begin
          if (abort) begin
            state     <= IDLE;
            sh        <= '0;
            cnt       <= '0;
            sdo       <= 1'b0;
            sdo_valid <= 1'b0;
            done      <= 1'b0;
            busy      <= 1'b0;
            din_ready <= 1'b1;
          end else if (cnt == LAST) begin
            cnt       <= '0;
            sdo       <= 1'b0;
            sdo_valid <= 1'b0;
            done      <= 1'b0;
            if (GAP_CYCLES == 0) begin
              state     <= IDLE;
              busy      <= 1'b0;
              din_ready <= 1'b1;
            end else begin
              state <= GAP;
              gcnt  <= GAP_LD;
            end
          end else begin
            sdo  <= msb_q ? sh[WIDTH-1] : sh[0];
            sh   <= msb_q ? sh << 1 : sh >> 1;
            cnt  <= cnt + 1'b1;
            done <= (cnt + 1'b1) == LAST;
          end
        end
        GAP: begin
          if (gcnt == 4'd0) begin
            state     <= IDLE;
            busy      <= 1'b0;
            din_ready <= 1'b1;
          end else begin
            gcnt <= gcnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
